// File: rtl/hex_display_scanner.sv
// Time-multiplexed driver for a common-anode hex display: captures a word on load,
// swaps it in only at frame boundaries and scans one digit per DIV clocks.
module hex_display_scanner #(
  parameter int NDIG = 8,
  parameter int DIV  = 50000,
  parameter int LZB  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [4*NDIG-1:0]         value,
  input  logic                      blank,
  output logic [3:0]                nibble,
  output logic [NDIG-1:0]           digit_en,
  output logic                      digit_blank,
  output logic [$clog2(NDIG)-1:0]   digit_idx,
  output logic                      frame
);

  localparam int IW  = $clog2(NDIG);
  localparam int PCW = $clog2(DIV);
  localparam logic [PCW-1:0]  PC_LAST  = PCW'(DIV - 1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(NDIG - 1);
  localparam logic [NDIG-1:0] EN_ONE   = NDIG'(1);

  logic [PCW-1:0]    pc_p0;
  logic [IW-1:0]     idx_p0;
  logic [4*NDIG-1:0] sh_p0;
  logic [4*NDIG-1:0] act_p0;
  logic              pend_p0;
  logic              wrapped_p0;

  logic step;
  logic wrap;
  logic off;

  function automatic logic [3:0] nib_of(input logic [4*NDIG-1:0] a,
                                        input logic [IW-1:0]     i);
    return a[4*i +: 4];
  endfunction

  // A digit is suppressed when it and every more significant digit is zero;
  // digit 0 always stays lit so a zero value still shows "0".
  function automatic logic lead_blank(input logic [4*NDIG-1:0] a,
                                      input logic [IW-1:0]     i);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int k = 0; k < NDIG; k++) begin
      if (k >= int'(i) && a[4*k +: 4] != 4'd0) upper_zero = 1'b0;
    end
    return (LZB != 0) && (i != '0) && upper_zero;
  endfunction

  always_comb begin
    step = (pc_p0 == PC_LAST);
    wrap = step && (idx_p0 == IDX_LAST);
    off  = blank | lead_blank(act_p0, idx_p0);
  end

  // Stage p0: prescaler, digit index and value double-buffering
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_p0      <= '0;
      idx_p0     <= '0;
      sh_p0      <= '0;
      act_p0     <= '0;
      pend_p0    <= 1'b0;
      wrapped_p0 <= 1'b0;
    end else begin
      pc_p0      <= step ? '0 : pc_p0 + 1'b1;
      wrapped_p0 <= wrap;
      if (step) idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + 1'b1;
      if (wrap && pend_p0) begin
        act_p0  <= sh_p0;
        pend_p0 <= 1'b0;
      end
      // A load on the wrap edge still hands the old shadow to act and stays pending.
      if (load) begin
        sh_p0   <= value;
        pend_p0 <= 1'b1;
      end
    end
  end

  // Stage p1: registered display outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nibble      <= '0;
      digit_en    <= '1;
      digit_blank <= 1'b1;
      digit_idx   <= '0;
      frame       <= 1'b0;
    end else begin
      nibble      <= nib_of(act_p0, idx_p0);
      digit_blank <= off;
      digit_en    <= off ? '1 : ~(EN_ONE << idx_p0);
      digit_idx   <= idx_p0;
      frame       <= wrapped_p0;
    end
  end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner (NDIG=8, DIV=4): directed phases plus random loads,
// checked each cycle against a cycle-count based model of the display.
module tb_hex_display_scanner;

  localparam int NDIG = 8;
  localparam int DIV  = 4;
  localparam int LZB  = 1;
  localparam int F    = NDIG * DIV;

  logic        clk;
  logic        reset;
  logic        load;
  logic [31:0] value;
  logic        blank;
  logic [3:0]  nibble;
  logic [7:0]  digit_en;
  logic        digit_blank;
  logic [2:0]  digit_idx;
  logic        frame;

  hex_display_scanner #(.NDIG(NDIG), .DIV(DIV), .LZB(LZB)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .blank(blank),
    .nibble(nibble), .digit_en(digit_en), .digit_blank(digit_blank),
    .digit_idx(digit_idx), .frame(frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          errs    = 0;
  int          n       = 0;
  logic [31:0] m_sh    = '0;
  logic [31:0] m_act   = '0;
  logic        m_pend  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, n);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_digit_en", 32'(digit_en), 32'hFF);
    chk("rst_digit_blank", 32'(digit_blank), 32'h1);
    chk("rst_nibble", 32'(nibble), 32'h0);
    chk("rst_digit_idx", 32'(digit_idx), 32'h0);
    chk("rst_frame", 32'(frame), 32'h0);
  endtask

  // One clock: n counts clocks since reset release; digit i is held for cycles
  // where (n/DIV)%NDIG == i and a wrap is the last cycle of every F-cycle frame.
  task automatic tick(input logic ld, input logic [31:0] v, input logic bl);
    int         ie;
    int         hi;
    logic       lz;
    logic       db;
    logic [7:0] en;
    logic [3:0] nb;
    logic       fr;
    load  = ld;
    value = v;
    blank = bl;
    ie = (n / DIV) % NDIG;
    hi = -1;
    for (int k = 0; k < NDIG; k++) if (m_act[4*k +: 4] != 4'd0) hi = k;
    lz = (LZB != 0) && (ie > 0) && (ie > hi);
    db = bl | lz;
    en = db ? 8'hFF : ~(8'h01 << ie);
    nb = m_act[4*ie +: 4];
    fr = (n % F == 0) && (n >= F);
    if ((n % F == F - 1) && m_pend) begin
      m_act  = m_sh;
      m_pend = 1'b0;
    end
    if (ld) begin
      m_sh   = v;
      m_pend = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("nibble", 32'(nibble), 32'(nb));
    chk("digit_en", 32'(digit_en), 32'(en));
    chk("digit_blank", 32'(digit_blank), 32'(db));
    chk("digit_idx", 32'(digit_idx), 32'(ie));
    chk("frame", 32'(frame), 32'(fr));
    n++;
  endtask

  task automatic idle(input int cnt, input logic bl);
    for (int i = 0; i < cnt; i++) tick(1'b0, $urandom, bl);
  endtask

  task automatic idle_to_idx(input int target);
    for (int i = 0; i < F && ((n / DIV) % NDIG) != target; i++) tick(1'b0, $urandom, 1'b0);
  endtask

  task automatic model_reset();
    n      = 0;
    m_sh   = '0;
    m_act  = '0;
    m_pend = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    load  = 1'b0;
    value = '0;
    blank = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    idle(40, 1'b0);

    // scan order
    tick(1'b1, 32'h1234ABCD, 1'b0);
    idle(80, 1'b0);

    // leading-zero blanking
    tick(1'b1, 32'h000000A0, 1'b0);
    idle(70, 1'b0);
    tick(1'b1, 32'h00000000, 1'b0);
    idle(70, 1'b0);

    // tear-free update, then a load on the wrap cycle itself
    tick(1'b1, 32'h11111111, 1'b0);
    idle(F, 1'b0);
    idle_to_idx(3);
    tick(1'b1, 32'h22222222, 1'b0);
    idle(2 * F, 1'b0);
    for (int i = 0; i < F && (n % F) != F - 1; i++) tick(1'b0, $urandom, 1'b0);
    tick(1'b1, 32'h33333333, 1'b0);
    idle(3 * F, 1'b0);

    // blank held for 10 cycles mid-frame
    idle_to_idx(4);
    idle(10, 1'b1);
    idle(40, 1'b0);

    // random loads, values with varying leading zeros, sporadic blank
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 12) == 0)
        tick(1'b1, $urandom >> $urandom_range(0, 32), $urandom_range(0, 16) == 0);
      else
        tick(1'b0, $urandom, $urandom_range(0, 16) == 0);
    end

    // asynchronous reset mid-scan with a load still pending
    idle_to_idx(2);
    tick(1'b1, 32'hDEADBEEF, 1'b0);
    idle(2, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    chk_reset_outputs();
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    reset = 1'b1;
    idle(3 * F, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
- Time-multiplexed driver for an NDIG-digit common-anode hex display.
- Captures a 4*NDIG-bit word (processor debug/register value) on a load strobe.
- Scans one digit at a time, presenting that digit's 4-bit nibble to the downstream seven-segment decoder and driving the active-low digit enables.
- Applies optional leading-zero blanking; updates the displayed value only at frame boundaries, so a frame never mixes old and new digits.

Parameters:
- NDIG, 8: number of digits; 2..16.
- DIV, 50000: clock cycles each digit is held; 2..2^20.
- LZB, 1: 1 enables leading-zero blanking, 0 disables it.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- load  in  1  capture request for value; sampled every cycle.
- value  in  4*NDIG  word to display; nibble i maps to digit i, digit 0 rightmost.
- blank  in  1  forces all digits off; scanning continues.
- nibble  out  4  hex nibble for the current digit, to the seven-segment decoder.
- digit_en  out  NDIG  active-low one-hot digit enable.
- digit_blank  out  1  1 means the downstream decoder output must be forced to all segments off.
- digit_idx  out  $clog2(NDIG)  index of the currently driven digit.
- frame  out  1  one-cycle pulse at the start of each scan frame.

Behaviour:
- State registers:
  - prescaler pc, 0..DIV-1
  - index idx, 0..NDIG-1
  - shadow register sh
  - active register act
  - pending flag pend
- Reset (async assert, reset=0), all clear:
  - pc=0, idx=0, sh=0, act=0, pend=0
  - outputs: digit_en=all ones, nibble=0, digit_blank=1, digit_idx=0, frame=0
- Prescaler:
  - pc increments each cycle.
  - At pc==DIV-1 it returns to 0 and asserts a step for that cycle.
- On a step:
  - idx increments.
  - idx==NDIG-1 wraps to 0; this is a "wrap".
- Load:
  - load=1 sets sh<=value and pend<=1 on that edge.
  - Repeated loads before a wrap overwrite sh; the last value wins.
- Wrap:
  - If pend=1: act<=sh and pend<=0.
  - If load=1 on the wrap cycle: act takes the old sh, sh takes the new value, pend stays 1, and the new value appears at the next wrap.
- Outputs are registered with one cycle of latency: outputs(t+1) = f(idx(t), act(t), blank(t)).
  - digit_idx = idx.
  - nibble = act[4*idx +: 4].
  - Digit idx counts as leading-zero blanked (lzb) when all of the following hold: LZB=1, idx!=0, and act nibbles idx..NDIG-1 are all zero.
  - Digit 0 is never blanked by LZB.
  - digit_blank = blank | lzb.
  - digit_en = all ones if digit_blank, else ~(1<<idx).
  - frame=1 in exactly the cycle in which the registered digit_idx first shows 0 after a wrap; otherwise 0.
  - No frame pulse on the first frame after reset.
- Dwell and timing:
  - Each digit is driven for exactly DIV cycles.
  - A frame is NDIG*DIV cycles.
  - A value loaded at cycle t is displayed starting at the first wrap after t, plus one cycle.
- Reset mid-scan: immediately returns to the reset values above, regardless of pc, idx, or pend. A pending load is discarded.
- blank toggling: affects only digit_blank/digit_en, with one cycle of latency. pc, idx, act, sh and pend are unaffected.
- X-handling: value is ignored when load=0.

Test Plan:
1. Reset check (NDIG=8, DIV=4): hold reset=0 → digit_en=8'hFF, digit_blank=1, frame=0. Release → next cycle digit_en=8'hFE, nibble=0, digit_idx=0; each digit lasts 4 cycles.
2. Scan order (LZB=0): load 32'h1234ABCD, wait one wrap → over the frame, nibble sequence D,C,B,A,4,3,2,1 with digit_en FE,FD,FB,F7,EF,DF,BF,7F; frame pulses once per 32 cycles.
3. Leading-zero blanking (LZB=1): load 32'h000000A0 → digits 7..2 have digit_blank=1 and digit_en=FF; digit 1 shows nibble A with digit_en FD; digit 0 shows nibble 0 with digit_en FE. Load 0 → only digit 0 is lit.
4. Tear-free update: load 32'h11111111, then load 32'h22222222 at idx=3 → the current frame still shows all 1s; the next frame shows all 2s. A load on the exact wrap cycle is deferred by one full frame.
5. Blank: assert blank for 10 cycles mid-frame → digit_en=FF from the following cycle. idx continues advancing; after release the scan resumes at the correct digit with no phase shift.
6. Reset mid-scan with pend=1 → outputs return to reset values asynchronously. After release, act=0 and the previously loaded value is never shown.
